uart_transceiver_top: RTL and testbench
=======================================

Name: uart_transceiver_top

Overview:
- Full-duplex 8N1 UART (start bit, 8 data bits LSB first, 1 stop bit, no parity), running in the single system clock domain.
- Baud timing comes from a clock-enable tick derived from CLK_FREQ/BAUD. No generated clocks.
- Sits between a byte-wide host interface (dintx/newd, doutrx/donerx) and the serial pins tx/rx.

Parameters:
- CLK_FREQ, 1000000: system clock frequency in Hz.
- BAUD, 9600: line rate in bits/s.
- Derived: CLKS_PER_BIT = CLK_FREQ/BAUD (integer division; 104 for defaults). CLKS_PER_BIT must be at least 4.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous reset, active-low.
- rx  input  1  serial receive line; idle high; asynchronous to clk.
- dintx  input  8  byte to transmit; captured at frame start.
- newd  input  1  transmit request, level-sensitive.
- tx  output  1  serial transmit line; idle high.
- doutrx  output  8  last correctly received byte.
- donetx  output  1  one-clk pulse when a TX frame completes.
- donerx  output  1  one-clk pulse when doutrx is updated.

Behaviour:
- Reset (rst low, asynchronous): tx=1, doutrx=0x00, donetx=0, donerx=0, both FSMs to IDLE, counters cleared.
- Reset mid-frame aborts the frame immediately. The line returns high. No done pulse is produced.
- TX baud counter: free-running 0..CLKS_PER_BIT-1 while TX is IDLE; tx_tick is asserted when the count wraps. A frame start resets the counter, so each bit lasts exactly CLKS_PER_BIT clks.
- TX FSM:
  - IDLE: tx=1. When newd=1 on a tx_tick, latch dintx into the shift register, drive tx=0 and go to START.
  - START: after CLKS_PER_BIT clks, drive bit0 and go to DATA.
  - DATA: each bit is held for CLKS_PER_BIT clks. After bit7, drive tx=1 and go to STOP.
  - STOP: after CLKS_PER_BIT clks, pulse donetx for 1 clk and return to IDLE.
- TX rules:
  - Total frame length is 10*CLKS_PER_BIT clks.
  - Changes to dintx or newd mid-frame are ignored.
  - If newd is still high after a frame, the next frame starts on the next tx_tick (back-to-back operation). The host deasserts newd to stop.
- RX input: rx passes through a 2-flop synchronizer.
- RX FSM:
  - IDLE: a synchronized high-to-low transition starts a counter and moves to START.
  - START: at CLKS_PER_BIT/2 clks, re-check rx. If high, treat as a glitch and go to IDLE. If low, go to DATA.
  - DATA: sample rx every CLKS_PER_BIT clks (mid-bit), 8 samples, shifting in LSB first.
  - STOP: sample at mid-stop-bit.
    - If 1: load doutrx and pulse donerx for 1 clk in the same cycle.
    - If 0 (framing error): discard the byte, leave doutrx unchanged, no donerx, and wait for rx high before returning to IDLE.
- RX returns to IDLE right after the stop-bit sample, so a following start edge is detected without loss.
- TX and RX are fully independent; simultaneous activity is legal.

Decomposition:
- Package uart_pkg: enum typedef of TX/RX states (IDLE, START, DATA, STOP); function computing CLKS_PER_BIT from CLK_FREQ and BAUD.
- Sub-module uart_baud_cnt: a restartable counter, instantiated once for TX and once for RX (RX issues a half-bit first event). The FSMs live in the top.

Test Plan:
- Reset: hold rst low 5 clks, then release -> tx=1, doutrx=0x00, donetx=0, donerx=0. No activity without newd or an rx edge.
- TX 0xA5: newd=1 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each level 104 clks. donetx pulses 1 clk at the end of the stop bit. Repeat for 10 random bytes, comparing captured bits to dintx.
- RX 0x3C: drive a frame 0,0,0,1,1,1,1,0,0,1 at 104 clks per bit -> doutrx=0x3C with a 1-clk donerx pulse at mid-stop-bit. Repeat for 10 random bytes.
- RX robustness: a 40-clk low glitch on rx -> no donerx. A frame with stop bit 0 -> no donerx and doutrx unchanged.
- Back-to-back and full-duplex: newd held high for 2 frames (0x55, 0xFF) while an RX frame 0x81 arrives concurrently -> 2 donetx pulses spaced 1040 clks apart; doutrx=0x81.
- Reset mid-frame: assert rst low during TX bit 3 -> tx=1 immediately, no donetx. A fresh frame after release is correct.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transceiver slice.
//   uart_state_t  : FSM state encoding used by both the TX and RX machines.
//   clks_per_bit  : system clocks per serial bit (integer division).
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Restartable baud-rate counter producing a one-clk tick per bit period.
//   clk, rst   : system clock, asynchronous active-low reset
//   restart    : clear the count; the next tick is one period away
//   half_first : with restart, make the first period half a bit long
//                (lets the receiver land in the middle of each bit)
//   tick       : asserted for one clk on the last count of a period
import uart_pkg::*;

module uart_baud_cnt #(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic half_first,
  output logic tick
);

  localparam int unsigned W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] FULL_LAST = W'(CLKS_PER_BIT - 1);
  localparam logic [W-1:0] HALF_LAST = W'(CLKS_PER_BIT / 2 - 1);

  logic [W-1:0] cnt;
  logic         half;

  // tick is not gated by restart: the TX FSM decides to restart on a tick,
  // so gating would form a combinational loop.
  assign tick = (cnt == (half ? HALF_LAST : FULL_LAST));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      half <= 1'b0;
    end else if (restart) begin
      cnt  <= '0;
      half <= half_first;
    end else if (tick) begin
      cnt  <= '0;
      half <= 1'b0;
    end else begin
      cnt  <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_transceiver_top.sv
// Full-duplex 8N1 UART, single clock domain, tick-enable baud timing.
//   clk, rst : system clock, asynchronous active-low reset
//   rx       : serial input (idle high, asynchronous)
//   dintx    : byte to send, captured when a frame starts
//   newd     : level-sensitive transmit request
//   tx       : serial output (idle high)
//   doutrx   : last byte received with a valid stop bit
//   donetx   : one-clk pulse at the end of each TX stop bit
//   donerx   : one-clk pulse when doutrx is loaded
import uart_pkg::*;

module uart_transceiver_top #(
  parameter int unsigned CLK_FREQ = 1000000,
  parameter int unsigned BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic [7:0] dintx,
  input  logic       newd,
  output logic       tx,
  output logic [7:0] doutrx,
  output logic       donetx,
  output logic       donerx
);

  localparam int unsigned CPB = clks_per_bit(CLK_FREQ, BAUD);

  // ---------------------------------------------------------------- TX
  uart_state_t tx_state;
  logic [7:0]  tx_sh;
  logic [2:0]  tx_idx;
  logic        tx_tick;
  logic        tx_restart;

  // A frame starts from IDLE, or straight out of STOP when newd is still
  // held, so back-to-back frames are exactly 10 bit periods apart.
  assign tx_restart = tx_tick && newd &&
                      ((tx_state == ST_IDLE) || (tx_state == ST_STOP));

  uart_baud_cnt #(.CLKS_PER_BIT(CPB)) u_tx_baud (
    .clk        (clk),
    .rst        (rst),
    .restart    (tx_restart),
    .half_first (1'b0),
    .tick       (tx_tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= ST_IDLE;
      tx_sh    <= '0;
      tx_idx   <= '0;
      tx       <= 1'b1;
      donetx   <= 1'b0;
    end else begin
      donetx <= 1'b0;
      if (tx_tick) begin
        case (tx_state)
          ST_IDLE: begin
            if (newd) begin
              tx_sh    <= dintx;
              tx       <= 1'b0;
              tx_state <= ST_START;
            end
          end
          ST_START: begin
            tx       <= tx_sh[0];
            tx_sh    <= {1'b0, tx_sh[7:1]};
            tx_idx   <= '0;
            tx_state <= ST_DATA;
          end
          ST_DATA: begin
            if (tx_idx == 3'd7) begin
              tx       <= 1'b1;
              tx_state <= ST_STOP;
            end else begin
              tx     <= tx_sh[0];
              tx_sh  <= {1'b0, tx_sh[7:1]};
              tx_idx <= tx_idx + 3'd1;
            end
          end
          ST_STOP: begin
            donetx <= 1'b1;
            if (newd) begin
              tx_sh    <= dintx;
              tx       <= 1'b0;
              tx_state <= ST_START;
            end else begin
              tx_state <= ST_IDLE;
            end
          end
          default: tx_state <= ST_IDLE;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------- RX
  uart_state_t rx_state;
  logic [7:0]  rx_sh;
  logic [2:0]  rx_idx;
  logic        rx_s1, rx_s2, rx_prev;
  logic        rx_fall;
  logic        rx_tick;
  logic        rx_restart;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // After a framing error the line may stay low; only a fresh high-to-low
  // edge restarts reception, which covers the wait-for-high condition.
  assign rx_fall    = rx_prev & ~rx_s2;
  assign rx_restart = (rx_state == ST_IDLE) && rx_fall;

  uart_baud_cnt #(.CLKS_PER_BIT(CPB)) u_rx_baud (
    .clk        (clk),
    .rst        (rst),
    .restart    (rx_restart),
    .half_first (1'b1),
    .tick       (rx_tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state <= ST_IDLE;
      rx_sh    <= '0;
      rx_idx   <= '0;
      doutrx   <= '0;
      donerx   <= 1'b0;
    end else begin
      donerx <= 1'b0;
      case (rx_state)
        ST_IDLE: begin
          if (rx_fall) rx_state <= ST_START;
        end
        ST_START: begin
          if (rx_tick) begin
            if (rx_s2) begin
              rx_state <= ST_IDLE;
            end else begin
              rx_idx   <= '0;
              rx_state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (rx_tick) begin
            rx_sh <= {rx_s2, rx_sh[7:1]};
            if (rx_idx == 3'd7) rx_state <= ST_STOP;
            else                rx_idx   <= rx_idx + 3'd1;
          end
        end
        ST_STOP: begin
          if (rx_tick) begin
            if (rx_s2) begin
              doutrx <= rx_sh;
              donerx <= 1'b1;
            end
            rx_state <= ST_IDLE;
          end
        end
        default: rx_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transceiver_top.sv
// Scoreboard bench for uart_transceiver_top: stimulus pushes expected bytes,
// independent TX and RX monitors pop and compare when the DUT presents them.
module tb_uart_transceiver_top;

  localparam int unsigned CPB   = 104;
  localparam int unsigned FRAME = 10 * CPB;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] dintx;
  logic       newd;
  logic       tx;
  logic [7:0] doutrx;
  logic       donetx;
  logic       donerx;

  int vectors;
  int miscompares;

  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];
  logic [7:0] last_good;

  uart_transceiver_top #(.CLK_FREQ(1000000), .BAUD(9600)) dut (
    .clk    (clk),
    .rst    (rst),
    .rx     (rx),
    .dintx  (dintx),
    .newd   (newd),
    .tx     (tx),
    .doutrx (doutrx),
    .donetx (donetx),
    .donerx (donerx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Follow one TX frame from the negedge where tx was first seen low.
  task automatic run_tx_frame(output logic tx_prev);
    logic [9:0]  bits;
    logic [7:0]  e;
    int unsigned k, j;
    logic        seen_done, aborted;
    bits = '0; k = 0; seen_done = 1'b0; aborted = 1'b0;
    while (k < FRAME + 50 && !seen_done && !aborted) begin
      @(negedge clk);
      k++;
      if (!rst) aborted = 1'b1;
      else begin
        if (k >= CPB/2 && ((k - CPB/2) % CPB) == 0) begin
          j = (k - CPB/2) / CPB;
          if (j <= 9) bits[j] = tx;
        end
        if (donetx) seen_done = 1'b1;
      end
    end
    tx_prev = 1'b1;
    if (aborted) begin
      chk("tx_idle_on_abort", tx, 1);
      chk("donetx_on_abort", donetx, 0);
    end else begin
      chk("tx_frame_len", k, FRAME);
      chk("tx_start_bit", bits[0], 0);
      chk("tx_stop_bit", bits[9], 1);
      chk("tx_frame_expected", exp_tx.size() != 0, 1);
      if (exp_tx.size() != 0) begin
        e = exp_tx.pop_front();
        chk("tx_byte", bits[8:1], e);
      end
    end
  endtask

  initial begin : tx_mon
    logic tx_prev;
    tx_prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst) tx_prev = 1'b1;
      else begin
        if (donetx) chk("donetx_spurious", donetx, 0);
        while (rst && tx_prev && !tx) run_tx_frame(tx_prev);
        tx_prev = tx;
      end
    end
  end

  initial begin : rx_mon
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst && donerx) begin
        chk("rx_frame_expected", exp_rx.size() != 0, 1);
        if (exp_rx.size() != 0) begin
          e = exp_rx.pop_front();
          chk("rx_byte", doutrx, e);
        end
      end
    end
  end

  initial begin : watchdog
    #(80000 * 10);
    $display("FAIL watchdog: simulation did not complete, vectors %0d", vectors);
    $fatal(1, "timeout");
  end

  task automatic wait_tx_fall();
    int unsigned n;
    n = 0;
    while (tx !== 1'b0 && n < 3 * CPB) begin
      @(negedge clk);
      n++;
    end
    chk("tx_start_seen", tx, 0);
  endtask

  task automatic wait_tx_idle();
    int unsigned n;
    n = 0;
    while (exp_tx.size() != 0 && n < FRAME + 300) begin
      @(negedge clk);
      n++;
    end
    chk("tx_frame_done", exp_tx.size(), 0);
  endtask

  task automatic send_tx(input logic [7:0] b);
    @(posedge clk); #1;
    dintx = b;
    newd  = 1'b1;
    exp_tx.push_back(b);
    wait_tx_fall();
    newd  = 1'b0;
    dintx = ~b;             // must be ignored mid-frame
    wait_tx_idle();
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    @(posedge clk); #1;
    if (stop_bit) begin
      exp_rx.push_back(b);
      last_good = b;
    end
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rx = 1'b1;
    if (stop_bit) chk("rx_done_within_stop", exp_rx.size(), 0);
  endtask

  initial begin : stim
    int unsigned n;
    vectors = 0; miscompares = 0; last_good = '0;
    rst = 1'b0; rx = 1'b1; newd = 1'b0; dintx = '0;

    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("reset_tx", tx, 1);
    chk("reset_doutrx", doutrx, 8'h00);
    chk("reset_donetx", donetx, 0);
    chk("reset_donerx", donerx, 0);
    repeat (300) @(negedge clk);
    chk("idle_tx", tx, 1);
    chk("idle_doutrx", doutrx, 8'h00);

    send_tx(8'hA5);
    for (int i = 0; i < 10; i++) send_tx(8'($urandom_range(255)));

    send_rx(8'h3C, 1'b1);
    for (int i = 0; i < 10; i++) send_rx(8'($urandom_range(255)), 1'b1);

    // short low glitch must be rejected at the half-bit recheck
    @(posedge clk); #1 rx = 1'b0;
    repeat (40) @(posedge clk);
    #1 rx = 1'b1;
    repeat (300) @(negedge clk);
    chk("doutrx_after_glitch", doutrx, last_good);

    // framing error: byte discarded
    send_rx(8'h5A, 1'b0);
    repeat (300) @(negedge clk);
    chk("doutrx_after_frame_err", doutrx, last_good);

    // back-to-back TX while RX runs concurrently
    fork
      begin
        @(posedge clk); #1;
        dintx = 8'h55; newd = 1'b1;
        exp_tx.push_back(8'h55);
        wait_tx_fall();
        dintx = 8'hFF;
        exp_tx.push_back(8'hFF);
        n = 0;
        while (!donetx && n < FRAME + 200) begin
          @(negedge clk);
          n++;
        end
        chk("b2b_first_done", donetx, 1);
        newd = 1'b0; dintx = 8'h00;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!donetx && n < FRAME + 200);
        chk("b2b_done_spacing", n, FRAME);
        wait_tx_idle();
      end
      begin
        repeat (37) @(posedge clk);
        send_rx(8'h81, 1'b1);
      end
    join
    repeat (50) @(negedge clk);
    chk("duplex_doutrx", doutrx, 8'h81);

    // reset during TX data bit 3: frame aborted, nothing expected
    @(posedge clk); #1;
    dintx = 8'h96; newd = 1'b1;
    wait_tx_fall();
    newd = 1'b0;
    repeat (4 * CPB + CPB / 2) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("tx_high_in_reset", tx, 1);
    chk("donetx_in_reset", donetx, 0);
    chk("doutrx_in_reset", doutrx, 8'h00);
    last_good = 8'h00;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    repeat (300) @(negedge clk);
    chk("tx_idle_after_reset", tx, 1);
    send_tx(8'h69);
    send_rx(8'hC3, 1'b1);

    repeat (50) @(negedge clk);
    chk("tx_queue_drained", exp_tx.size(), 0);
    chk("rx_queue_drained", exp_rx.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
